branch_resolve_queue: RTL

In-order queue of in-flight conditional branches, sitting between decode/dispatch and execute on one side and `branch_predictor` on the other. Decode enqueues each branch with its prediction and receives a tag. Execute resolves branches out of order by tag. The queue retires resolved branches in program order, drives the predictor's training inputs (`branch_we`/`branch_taken`), and raises a mispredict redirect that empties the queue.

---
 rtl/branch_resolve_queue_pkg.sv | 25 ++
 rtl/branch_resolve_queue_if.sv | 34 +++
 rtl/branch_resolve_queue.sv | 89 ++++++++
 3 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and helpers for the in-order branch resolve queue.
// Holds the default depth and the per-entry record kept for each in-flight branch.
package branch_resolve_queue_pkg;

  localparam int BQ_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        act_taken;
    logic [31:0] act_target;
  } bq_entry_t;

  // Wrong direction, or right direction (taken) but wrong destination.
  function automatic logic is_mispredict(input bq_entry_t e);
    return (e.act_taken != e.pred_taken) ||
           (e.act_taken && (e.act_target != e.pred_target));
  endfunction

  function automatic logic [31:0] redirect_target(input bq_entry_t e);
    return e.act_taken ? e.act_target : (e.pc + 32'd4);
  endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Decode/execute/predictor-facing signal bundle of the branch resolve queue.
// master = decode + execute + predictor side, slave = the queue itself.
interface branch_resolve_queue_if #(
  parameter int TAG_W = 3
) ();

  logic             enq_valid;
  logic             enq_ready;
  logic [31:0]      enq_pc;
  logic             enq_pred_taken;
  logic [31:0]      enq_pred_target;
  logic [TAG_W-1:0] enq_tag;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             branch_we;
  logic             branch_taken;
  logic             mispredict;
  logic [31:0]      redirect_pc;

  modport master (
    output enq_valid, enq_pc, enq_pred_taken, enq_pred_target,
    output res_valid, res_tag, res_taken, res_target,
    input  enq_ready, enq_tag, branch_we, branch_taken, mispredict, redirect_pc
  );

  modport slave (
    input  enq_valid, enq_pc, enq_pred_taken, enq_pred_target,
    input  res_valid, res_tag, res_taken, res_target,
    output enq_ready, enq_tag, branch_we, branch_taken, mispredict, redirect_pc
  );

endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight conditional branches: enqueue with prediction, resolve
// out of order by tag, retire in program order, flush everything on a mispredict.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int BQ_DEPTH = BQ_DEPTH_DEFAULT,
  parameter int TAG_W    = $clog2(BQ_DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  branch_resolve_queue_if.slave bq
);

  localparam logic [TAG_W:0]   DEPTH_CNT = (TAG_W+1)'(BQ_DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE   = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE   = TAG_W'(1);

  bq_entry_t           entries [BQ_DEPTH];
  logic [BQ_DEPTH-1:0] valid_q;
  logic [BQ_DEPTH-1:0] resolved_q;
  logic [TAG_W-1:0]    head_q;
  logic [TAG_W-1:0]    tail_q;
  logic [TAG_W:0]      count_q;

  bq_entry_t head_ent;
  logic      retire;
  logic      flush;
  logic      enq_fire;
  logic      res_hit;

  // Retire decision is purely a function of registered state.
  always_comb begin
    head_ent = entries[head_q];
    retire   = valid_q[head_q] & resolved_q[head_q];
    flush    = retire & is_mispredict(head_ent);
    enq_fire = bq.enq_valid & (count_q != DEPTH_CNT);
    res_hit  = bq.res_valid & valid_q[bq.res_tag];
  end

  assign bq.enq_ready    = (count_q != DEPTH_CNT);
  assign bq.enq_tag      = tail_q;
  assign bq.branch_we    = retire;
  assign bq.branch_taken = retire & head_ent.act_taken;
  assign bq.mispredict   = flush;
  assign bq.redirect_pc  = flush ? redirect_target(head_ent) : 32'd0;

  // Control state; a flush drops any same-cycle enqueue/resolve as younger work.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q    <= '0;
      resolved_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      if (enq_fire) begin
        valid_q[tail_q]    <= 1'b1;
        resolved_q[tail_q] <= 1'b0;
        tail_q             <= tail_q + TAG_ONE;
      end
      if (res_hit) begin
        resolved_q[bq.res_tag] <= 1'b1;
      end
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + TAG_ONE;
      end
      case ({enq_fire, retire})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload is only meaningful under valid/resolved, so it is never reset.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      entries[tail_q].pc          <= bq.enq_pc;
      entries[tail_q].pred_taken  <= bq.enq_pred_taken;
      entries[tail_q].pred_target <= bq.enq_pred_target;
    end
    if (res_hit) begin
      entries[bq.res_tag].act_taken  <= bq.res_taken;
      entries[bq.res_tag].act_target <= bq.res_target;
    end
  end

endmodule
